// File: rtl/neuron_accum_if.sv
// Handshake bundle for the neuron accumulator: pass control, product stream and result.
// The master drives requests and data; the slave (the accumulator) drives status and result.
interface neuron_accum_if;
  logic               start;
  logic signed [21:0] bias;
  logic               in_valid;
  logic signed [19:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic signed [21:0] out_sum;
  logic               out_ready;
  logic               busy;
  logic               ovf;

  modport master (
    output start, bias, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy, ovf
  );

  modport slave (
    input  start, bias, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy, ovf
  );
endinterface

// File: rtl/neuron_accum_ctrl.sv
// Per-neuron multiply-accumulate controller: seeds a 22-bit accumulator with a bias,
// sums N_INPUTS signed products one per cycle, then holds the result until it is taken.
module neuron_accum_ctrl #(
  parameter int N_INPUTS = 784,
  parameter int CNT_W    = 10
) (
  input logic           clk,
  input logic           rst,
  neuron_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  state_e             state_q,     state_d;
  logic signed [21:0] acc_q,       acc_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               ovf_q,       ovf_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic signed [21:0] in_ext;
  logic signed [21:0] sum;
  logic               xfer;
  logic               load;
  logic               sum_ovf;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ext  = {{2{bus.in_data[19]}}, bus.in_data};
    sum     = acc_q + in_ext;
    sum_ovf = (acc_q[21] == in_ext[21]) && (sum[21] != acc_q[21]);
    xfer    = in_ready_q && bus.in_valid;
    load    = 1'b0;

    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        load = bus.start;
      end
      S_ACC: begin
        if (xfer) begin
          acc_d   = sum;
          count_d = count_q + CNT_W'(1);
          ovf_d   = ovf_q | sum_ovf;
          if (count_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = S_IDLE;
          load    = bus.start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accepted start reseeds the pass and overrides any return to IDLE.
    if (load) begin
      state_d = S_ACC;
      acc_d   = bus.bias;
      count_d = '0;
      ovf_d   = 1'b0;
    end

    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Directed bench for neuron_accum_ctrl: one N_INPUTS=4 instance and one N_INPUTS=2 instance
// driven from a linear sequence of steps with hand-computed expectations.
module tb_neuron_accum_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  neuron_accum_if a4 ();
  neuron_accum_if a2 ();

  neuron_accum_ctrl #(.N_INPUTS(4), .CNT_W(10)) u4 (.clk(clk), .rst(rst), .bus(a4));
  neuron_accum_ctrl #(.N_INPUTS(2), .CNT_W(10)) u2 (.clk(clk), .rst(rst), .bus(a2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed4(input int v);
    a4.in_valid = 1'b1;
    a4.in_data  = 20'(v);
    tick();
    a4.in_valid = 1'b0;
  endtask

  task automatic feed2(input int v);
    a2.in_valid = 1'b1;
    a2.in_data  = 20'(v);
    tick();
    a2.in_valid = 1'b0;
  endtask

  initial begin
    a4.start = 0; a4.bias = '0; a4.in_valid = 0; a4.in_data = '0; a4.out_ready = 0;
    a2.start = 0; a2.bias = '0; a2.in_valid = 0; a2.in_data = '0; a2.out_ready = 0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",      22'(a4.busy),      22'd0);
    check("rst_out_valid", 22'(a4.out_valid), 22'd0);
    check("rst_in_ready",  22'(a4.in_ready),  22'd0);
    check("rst_ovf",       22'(a4.ovf),       22'd0);
    check("rst_acc",       u4.acc_q,          22'd0);

    // Bias 10, products 1..4 back to back: result after 5 cycles
    a4.start = 1'b1; a4.bias = 22'sd10;
    tick();
    a4.start = 1'b0;
    check("p1_busy",     22'(a4.busy),     22'd1);
    check("p1_in_ready", 22'(a4.in_ready), 22'd1);
    feed4(1); feed4(2); feed4(3);
    check("p1_not_yet_valid", 22'(a4.out_valid), 22'd0);
    feed4(4);
    check("p1_out_valid", 22'(a4.out_valid), 22'd1);
    check("p1_sum",       a4.out_sum,        22'sd20);
    check("p1_ovf",       22'(a4.ovf),       22'd0);
    check("p1_in_ready_done", 22'(a4.in_ready), 22'd0);
    a4.out_ready = 1'b1;
    tick();
    a4.out_ready = 1'b0;
    check("p1_idle_busy",  22'(a4.busy),      22'd0);
    check("p1_idle_valid", 22'(a4.out_valid), 22'd0);

    // Bias -5, products -1, 0, three-cycle gap, -2, 7
    a4.start = 1'b1; a4.bias = -22'sd5;
    tick();
    a4.start = 1'b0;
    feed4(-1); feed4(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_acc",   u4.acc_q,          -22'sd6);
      check("gap_count", 22'(u4.count_q),   22'd2);
      check("gap_ready", 22'(a4.in_ready),  22'd1);
    end
    feed4(-2); feed4(7);
    check("p2_out_valid", 22'(a4.out_valid), 22'd1);
    check("p2_sum",       a4.out_sum,        -22'sd1);
    check("p2_ovf",       22'(a4.ovf),       22'd0);

    // Hold in DONE with out_ready low; start alone must be ignored
    for (int i = 0; i < 4; i++) begin
      a4.start = (i == 1);
      a4.bias  = 22'sd77;
      tick();
      check("hold_sum",   a4.out_sum,        -22'sd1);
      check("hold_valid", 22'(a4.out_valid), 22'd1);
    end
    a4.start = 1'b0;

    // Completing handshake with start: straight back into ACC with bias 3
    a4.out_ready = 1'b1; a4.start = 1'b1; a4.bias = 22'sd3;
    tick();
    a4.out_ready = 1'b0; a4.start = 1'b0;
    check("b2b_busy",     22'(a4.busy),      22'd1);
    check("b2b_in_ready", 22'(a4.in_ready),  22'd1);
    check("b2b_valid",    22'(a4.out_valid), 22'd0);
    check("b2b_acc",      u4.acc_q,          22'sd3);
    check("b2b_count",    22'(u4.count_q),   22'd0);

    // Start pulsed mid-pass is ignored: 3 + 1 + 2 + 3 + 4 = 13
    feed4(1);
    a4.start = 1'b1; a4.bias = 22'sd100;
    feed4(2);
    a4.start = 1'b0;
    feed4(3); feed4(4);
    check("p3_valid", 22'(a4.out_valid), 22'd1);
    check("p3_sum",   a4.out_sum,        22'sd13);
    a4.out_ready = 1'b1;
    tick();
    a4.out_ready = 1'b0;

    // Reset after 2 of 4 products, asserted together with start/in_valid/out_ready
    a4.start = 1'b1; a4.bias = 22'sd0;
    tick();
    a4.start = 1'b0;
    feed4(5); feed4(6);
    rst = 1'b1; a4.start = 1'b1; a4.bias = 22'sd9; a4.in_valid = 1'b1; a4.in_data = 20'sd1;
    a4.out_ready = 1'b1;
    tick();
    rst = 1'b0; a4.start = 1'b0; a4.in_valid = 1'b0; a4.out_ready = 1'b0;
    check("mid_rst_busy",  22'(a4.busy),      22'd0);
    check("mid_rst_valid", 22'(a4.out_valid), 22'd0);
    check("mid_rst_acc",   u4.acc_q,          22'd0);
    tick(); tick();
    check("mid_rst_stay_idle", 22'(a4.out_valid), 22'd0);
    a4.start = 1'b1; a4.bias = 22'sd0;
    tick();
    a4.start = 1'b0;
    feed4(1); feed4(1); feed4(1); feed4(1);
    check("p4_valid", 22'(a4.out_valid), 22'd1);
    check("p4_sum",   a4.out_sum,        22'sd4);
    a4.out_ready = 1'b1;
    tick();
    a4.out_ready = 1'b0;

    // N_INPUTS=2: positive overflow wraps to 0x200000 and sets the sticky flag
    a2.start = 1'b1; a2.bias = 22'h1FFFFF;
    tick();
    a2.start = 1'b0;
    feed2(1);
    check("ovf_set_early", 22'(a2.ovf), 22'd1);
    feed2(0);
    check("ovf_valid", 22'(a2.out_valid), 22'd1);
    check("ovf_sum",   a2.out_sum,        22'h200000);
    check("ovf_flag",  22'(a2.ovf),       22'd1);
    a2.out_ready = 1'b1; a2.start = 1'b1; a2.bias = 22'h200000;
    tick();
    a2.out_ready = 1'b0; a2.start = 1'b0;
    check("ovf_cleared", 22'(a2.ovf), 22'd0);

    // Negative overflow: -2^21 + -1 wraps to 0x1FFFFF
    feed2(-1);
    feed2(0);
    check("novf_sum",  a2.out_sum,  22'h1FFFFF);
    check("novf_flag", 22'(a2.ovf), 22'd1);
    a2.out_ready = 1'b1;
    tick();
    a2.out_ready = 1'b0;
    check("novf_idle", 22'(a2.busy), 22'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_accum_ctrl.md
NEURON_ACCUM_CTRL -- requirements
Module: neuron_accum_ctrl

Interface
REQ-001 Parameter N_INPUTS, default 784, number of products accumulated per neuron pass (legal range 1..1023).
REQ-002 Parameter CNT_W, default 10, width of the input counter (2^CNT_W > N_INPUTS-1).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a pass; sampled per REQ-012 and REQ-016.
REQ-007 bias  input  22  signed bias, sampled on an accepted start.
REQ-008 in_valid  input  1  in_data holds a valid product.
REQ-009 in_data  input  20  signed product term.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 out_valid, out_sum[21:0] (signed), out_ready (input), busy, ovf: result handshake, pass-in-progress flag, sticky signed-overflow flag.

Function
REQ-012 States IDLE, ACC, DONE; start in IDLE loads acc <= bias, count <= 0, ovf <= 0, state -> ACC next cycle.
REQ-013 In ACC, in_ready = 1; a transfer occurs on in_valid && in_ready, and then acc <= acc + sign_extend(in_data), wrapped modulo 2^22, and count <= count + 1.
REQ-014 ovf is set on any transfer where the operands have equal signs and the wrapped sum differs in sign; ovf holds until the next accepted start or reset.
REQ-015 A transfer with count == N_INPUTS-1 moves the state to DONE on the next cycle; no further products are accepted in that pass.
REQ-016 In DONE, out_valid = 1, out_sum = acc, in_ready = 0; out_valid && out_ready moves the state to IDLE, unless start is also high that cycle, in which case the new pass loads per REQ-012 and the state goes directly to ACC.
REQ-017 out_sum and out_valid hold stable in DONE while out_ready = 0.
REQ-018 start is ignored in ACC, and in DONE without a completing out_ready.
REQ-019 busy = 1 in ACC and DONE, 0 in IDLE.
REQ-020 in_ready and out_valid are driven from state only, with no combinational path from in_valid or out_ready.
REQ-021 In_valid gaps in ACC stall accumulation without changing acc, count or state.
REQ-022 Throughput is one product per cycle; pass latency is N_INPUTS + 1 cycles from start to out_valid with no in_valid gaps.

Reset
REQ-023 rst forces state IDLE, acc = 0, count = 0, ovf = 0, out_valid = 0, in_ready = 0, busy = 0 on the next edge.
REQ-024 rst during ACC or DONE discards the pass; no out_valid follows until a new start.
REQ-025 rst has priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-026 N_INPUTS=4, bias=10, products 1, 2, 3, 4 with in_valid held high -> out_valid 5 cycles after start, out_sum=20, ovf=0.
REQ-027 N_INPUTS=4, bias=-5, products -1, 0, in_valid low 3 cycles, then -2, 7 -> out_sum=-1, with acc and count unchanged during the gap.
REQ-028 N_INPUTS=2, bias=0x1FFFFF, products 1, 0 -> out_sum=0x200000 (wrapped, -2097152), ovf=1; next start -> ovf=0.
REQ-029 In DONE, out_ready low 4 cycles -> out_sum stable; out_ready and start high together with bias=3 -> next cycle state ACC, acc=3, busy=1.
REQ-030 rst after 2 of 4 products -> busy=0 and out_valid=0 next cycle; start then with 4 products of 1 and bias 0 -> out_sum=4.
REQ-031 start pulsed during ACC -> ignored, and the result equals the single-pass expected sum.
